seg7_multi_ctrl: RTL and testbench
==================================

# seg7_multi_ctrl

Parametrised N-digit seven-segment display controller for the DE2-115 FPGA top level. It latches a value written by the processor's GPIO path and drives NUM_DIGITS seven-segment outputs. The value is shown either as hexadecimal, or as unsigned decimal through a multi-cycle binary-to-BCD (double-dabble) converter. Per-digit blink masking is supported, with optional leading-zero blanking. It supersedes the fixed 8-digit hex-only decode in the board top.

## Interface
Parameters:
- NUM_DIGITS, 8, number of seven-segment digits driven (1..8)
- DATA_WIDTH, 32, width of wr_data (multiple of 4, ≤ 32)
- BLINK_DIV_W, 20, width of free-running blink counter; MSB is blink phase
- SEG_ACTIVE_LOW, 1, 1 = segment lit on 0 (DE2-115), 0 = lit on 1

Ports:
- clk_div8  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe; accepted only when busy=0
- wr_data  in  DATA_WIDTH  value to display
- mode_dec  in  1  sampled with wr_en: 0 = hex, 1 = unsigned decimal
- blink_mask  in  NUM_DIGITS  bit i=1 blanks digit i during blink phase 1 (live, not latched)
- busy  out  1  decimal conversion in progress
- overflow  out  1  last decimal value exceeded 10^NUM_DIGITS−1
- seg_o  out  7*NUM_DIGITS  digit i at [7i+6:7i], bit order g,f,e,d,c,b,a

## Operation
- Segment codes, active-low form: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, dash=0111111, blank=1111111. When SEG_ACTIVE_LOW=0, all codes are inverted.
- FSM states:
  - IDLE:
    - wr_en with mode_dec=0: the digit register takes wr_data nibbles. Digits at or above DATA_WIDTH/4 are 0; nibbles above NUM_DIGITS are dropped. overflow is cleared. The FSM stays in IDLE.
    - wr_en with mode_dec=1: the shift register takes wr_data, the BCD register takes 0 and the counter takes DATA_WIDTH. The FSM goes to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. A 1 shifted out of the top BCD nibble sets a sticky ovf_acc. The counter decrements. When the counter reaches 0, the FSM goes to LOAD.
  - LOAD: the digit register takes bcd, and overflow takes ovf_acc. The FSM returns to IDLE.
- busy=1 in CONV and LOAD. wr_en while busy is ignored: no queueing and no error.
- Output stage, registered, per digit i:
  - overflow=1: dash on all digits.
  - Else, if blink_mask[i] and blink phase=1: blank.
  - Else, if leading-zero blanking applies: blank.
  - Else: decoded digit.
- Blink counter is free-running from reset and wraps modulo 2^BLINK_DIV_W.
- Reset values:
  - All seg_o digits show code "0".
  - busy=0, overflow=0, FSM in IDLE, blink counter 0, digit register 0.
- Reset mid-conversion aborts the conversion. No partial result reaches the digit register.

## Timing
- Hex write accepted at edge k: digit register updates at k; seg_o reflects it after edge k+1. Latency is 2 edges.
- Decimal write accepted at edge k: busy=1 after k, through DATA_WIDTH CONV cycles and 1 LOAD cycle. busy falls after edge k+DATA_WIDTH+1. seg_o updates after edge k+DATA_WIDTH+2.
- wr_en on the edge busy falls (the LOAD edge) is ignored. The first accepted write is at the next edge.
- A blink_mask change is visible on seg_o 1 edge later.
- Blink phase toggles every 2^(BLINK_DIV_W−1) cycles.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking is enabled.
  - Digits above the most significant nonzero digit are blanked.
  - Digit 0 is never blanked by this rule.
  - Blanking is suppressed while overflow=1.
- SEG7_LZ_BLANK_EN undefined: no leading-zero blanking; all NUM_DIGITS digits are always shown.

## Test plan
- Reset, then release: every 7-bit field of seg_o is 1000000; busy=0; overflow=0.
- Hex write 0x1234ABCD, defaults: digits 7..0 show 1,2,3,4,A,b,C,d. seg_o[6:0]=0100001 two edges after the accepting edge.
- Decimal write 12345678: busy is high for exactly 33 cycles; digits 7..0 show 1..8; overflow=0. With SEG7_LZ_BLANK_EN, a decimal write of 42 leaves digits 7..2 at 1111111, digit 1 = 4 and digit 0 = 2.
- Decimal write 0xFFFFFFFF: overflow=1 and all digits show 0111111. A following hex write of 0 clears overflow and shows all "0".
- Write during busy: a hex 0xFFFFFFFF write at cycle 10 of a conversion is dropped, and the decimal result is shown. Reset asserted at cycle 5 of a conversion gives busy=0 and all "0" immediately.
- BLINK_DIV_W=4, blink_mask=0x01: digit 0 alternates decoded/blank every 8 cycles; the other digits are stable.

Source files
------------

// File: rtl/seg7_multi_ctrl.sv
// N-digit seven-segment controller: hex or decimal (double-dabble) display with blink masking.
// Optional leading-zero blanking is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_multi_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BLINK_DIV_W    = 20,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_div8,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    mode_dec,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] seg_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [6:0] SEG_DASH  = SEG_ACTIVE_LOW ? 7'b0111111 : 7'b1000000;
    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [BCD_W-1:0]         r_digits;
    logic [BCD_W-1:0]         r_bcd;
    logic [BCD_W-1:0]         w_bcd_adj;
    logic [DATA_WIDTH-1:0]    r_bin;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf_acc;
    logic                     r_overflow;
    logic [BLINK_DIV_W-1:0]   r_blink_cnt;
    logic [7*NUM_DIGITS-1:0]  r_seg;
    logic [7*NUM_DIGITS-1:0]  w_seg_nxt;
    logic [31:0]              w_data_ext;
    logic [NUM_DIGITS-1:0]    w_lz_blank;
    logic                     w_blink_phase;

    // Segment pattern in active-low form, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0011000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Zero-extension gives 0 for digits beyond the written width.
    assign w_data_ext    = 32'(wr_data);
    assign w_blink_phase = r_blink_cnt[BLINK_DIV_W-1];

    // NOTE: async reset lives in the sensitivity list; every sequential block uses <= only.
    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (wr_en && mode_dec) w_state_nxt = CONV;
            CONV:    if (r_cnt == CNT_W'(1)) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_digits   <= '0;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_ovf_acc  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wr_en && !mode_dec) begin
                        r_digits   <= w_data_ext[BCD_W-1:0];
                        r_overflow <= 1'b0;
                    end else if (wr_en && mode_dec) begin
                        r_bin     <= wr_data;
                        r_bcd     <= '0;
                        r_cnt     <= CNT_W'(DATA_WIDTH);
                        r_ovf_acc <= 1'b0;
                    end
                end
                CONV: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // A carry out of the top digit means the value needs more digits than we have.
                    if (w_bcd_adj[BCD_W-1]) r_ovf_acc <= 1'b1;
                end
                LOAD: begin
                    r_digits   <= r_bcd;
                    r_overflow <= r_ovf_acc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_DIV_W'(1);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // Walk down from the top digit; blank while everything seen so far is zero.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (r_digits[4*i +: 4] == 4'h0);
            w_lz_blank[i] = zero_run && (i != 0) && !r_overflow;
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    always_comb begin
        w_seg_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_overflow) begin
                w_seg_nxt[7*i +: 7] = SEG_DASH;
            end else if (blink_mask[i] && w_blink_phase) begin
                w_seg_nxt[7*i +: 7] = SEG_BLANK;
            end else if (w_lz_blank[i]) begin
                w_seg_nxt[7*i +: 7] = SEG_BLANK;
            end else if (SEG_ACTIVE_LOW) begin
                w_seg_nxt[7*i +: 7] = seg_decode(r_digits[4*i +: 4]);
            end else begin
                w_seg_nxt[7*i +: 7] = ~seg_decode(r_digits[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk_div8 or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            r_seg <= w_seg_nxt;
        end
    end

    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;
    assign seg_o    = r_seg;

endmodule

// File: tb/tb_seg7_multi_ctrl.sv
// Directed self-checking bench for seg7_multi_ctrl: hex/decimal display, overflow, busy drop, reset abort, blink.
module tb_seg7_multi_ctrl;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    logic        clk_div8 = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        mode_dec;
    logic [7:0]  blink_mask;
    logic        busy;
    logic        overflow;
    logic [55:0] seg_o;

    logic        b_wr_en;
    logic [31:0] b_wr_data;
    logic        b_mode_dec;
    logic [7:0]  b_blink_mask;
    logic        b_busy;
    logic        b_overflow;
    logic [55:0] b_seg_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_div8 = ~clk_div8;

    seg7_multi_ctrl #(
        .NUM_DIGITS(8), .DATA_WIDTH(32), .BLINK_DIV_W(20), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk_div8(clk_div8), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .mode_dec(mode_dec), .blink_mask(blink_mask), .busy(busy),
        .overflow(overflow), .seg_o(seg_o)
    );

    seg7_multi_ctrl #(
        .NUM_DIGITS(8), .DATA_WIDTH(32), .BLINK_DIV_W(4), .SEG_ACTIVE_LOW(1'b1)
    ) u_blink (
        .clk_div8(clk_div8), .rst_n(rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .mode_dec(b_mode_dec), .blink_mask(b_blink_mask), .busy(b_busy),
        .overflow(b_overflow), .seg_o(b_seg_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] code7(input logic [3:0] n);
        case (n)
            4'h0: code7 = 7'b1000000;  4'h1: code7 = 7'b1111001;
            4'h2: code7 = 7'b0100100;  4'h3: code7 = 7'b0110000;
            4'h4: code7 = 7'b0011001;  4'h5: code7 = 7'b0010010;
            4'h6: code7 = 7'b0000010;  4'h7: code7 = 7'b1111000;
            4'h8: code7 = 7'b0000000;  4'h9: code7 = 7'b0011000;
            4'hA: code7 = 7'b0001000;  4'hB: code7 = 7'b0000011;
            4'hC: code7 = 7'b1000110;  4'hD: code7 = 7'b0100001;
            4'hE: code7 = 7'b0000110;  default: code7 = 7'b0001110;
        endcase
    endfunction

    // Expected display from packed digit values and a per-digit blank mask.
    function automatic logic [55:0] disp(input logic [31:0] digits, input logic [7:0] blank);
        disp = '0;
        for (int i = 0; i < 8; i++)
            disp[7*i +: 7] = blank[i] ? BLANK : code7(digits[4*i +: 4]);
    endfunction

    // Leading-zero blank mask the display should have for a given digit set.
    function automatic logic [7:0] lz(input logic [31:0] digits);
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = 7; i >= 1; i--) begin
            run   = run && (digits[4*i +: 4] == 4'h0);
            lz[i] = LZ_ON && run;
        end
    endfunction

    // Write, then wait until busy drops (bounded) plus one edge for the output register.
    task automatic do_write(input logic [31:0] d, input logic dec, output int busy_cyc);
        @(negedge clk_div8);
        wr_en = 1'b1; wr_data = d; mode_dec = dec;
        @(negedge clk_div8);
        wr_en = 1'b0; mode_dec = 1'b0;
        busy_cyc = 0;
        while (busy && busy_cyc < 100) begin
            busy_cyc++;
            @(negedge clk_div8);
        end
        @(negedge clk_div8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc;
        int busy_cnt;
        logic blink_on;

        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; mode_dec = 1'b0; blink_mask = '0;
        b_wr_en = 1'b0; b_wr_data = '0; b_mode_dec = 1'b0; b_blink_mask = 8'h01;

        repeat (2) @(negedge clk_div8);
        check("rst_seg", seg_o, disp(32'h0, 8'h00));
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // Blink counter on u_blink starts at 0 after release; output lags the phase by one edge.
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_div8);
            blink_on = (((n - 1) % 16) >= 8);
            check($sformatf("blink_n%0d", n), b_seg_o,
                  disp(32'h0, lz(32'h0) | {7'b0, blink_on}));
        end
        check("post_rst_seg", seg_o, disp(32'h0, lz(32'h0)));
        check("post_rst_busy", busy, 1'b0);

        // Hex write: two-edge latency.
        @(negedge clk_div8);
        wr_en = 1'b1; wr_data = 32'h1234ABCD; mode_dec = 1'b0;
        @(negedge clk_div8);
        wr_en = 1'b0;
        check("hex_lat1_d0", seg_o[6:0], code7(4'h0));
        check("hex_busy", busy, 1'b0);
        @(negedge clk_div8);
        check("hex_lat2_d0", seg_o[6:0], 7'b0100001);
        check("hex_seg", seg_o, disp(32'h1234ABCD, 8'h00));

        do_write(32'd12345678, 1'b1, bc);
        check("dec_busy_cycles", bc, 33);
        check("dec_ovf", overflow, 1'b0);
        check("dec_seg", seg_o, disp(32'h12345678, 8'h00));

        do_write(32'hFFFFFFFF, 1'b1, bc);
        check("ovf_busy_cycles", bc, 33);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_seg", seg_o, {8{DASH}});

        do_write(32'h0, 1'b0, bc);
        check("ovf_clr_flag", overflow, 1'b0);
        check("ovf_clr_seg", seg_o, disp(32'h0, lz(32'h0)));

        do_write(32'd42, 1'b1, bc);
        check("dec42_seg", seg_o, disp(32'h42, lz(32'h42)));

        // Writes at conversion cycle 10 and on the LOAD edge must both be dropped.
        @(negedge clk_div8);
        wr_en = 1'b1; wr_data = 32'd987654; mode_dec = 1'b1;
        busy_cnt = 0;
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk_div8);
            if (busy) busy_cnt++;
            wr_en    = (n == 10) || (n == 33);
            mode_dec = 1'b0;
            wr_data  = (n == 10) ? 32'hFFFFFFFF : 32'h00000055;
        end
        check("drop_busy_cycles", busy_cnt, 33);
        check("drop_busy_low", busy, 1'b0);
        @(negedge clk_div8);
        check("drop_seg", seg_o, disp(32'h00987654, lz(32'h00987654)));
        check("drop_ovf", overflow, 1'b0);
        @(negedge clk_div8);
        check("drop_seg_hold", seg_o, disp(32'h00987654, lz(32'h00987654)));

        // Reset at cycle 5 of a conversion.
        @(negedge clk_div8);
        wr_en = 1'b1; wr_data = 32'd12345678; mode_dec = 1'b1;
        @(negedge clk_div8);
        wr_en = 1'b0; mode_dec = 1'b0;
        repeat (4) @(negedge clk_div8);
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_seg", seg_o, disp(32'h0, 8'h00));
        check("abort_ovf", overflow, 1'b0);
        @(negedge clk_div8);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_div8);
        check("abort_busy_late", busy, 1'b0);
        check("abort_seg_late", seg_o, disp(32'h0, lz(32'h0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
